// File: rtl/btn_debounce_pkg.sv
// Shared constants and helpers for the button debounce path.
package btn_debounce_pkg;

  // 10 ms of stable input at the 125 MHz system clock.
  localparam int DEBOUNCE_10MS_125MHZ = 1250000;
  // Short window so simulation reaches acceptance in a handful of cycles.
  localparam int SIM_DEBOUNCE_CYCLES  = 4;
  // Number of push-buttons wired on the board.
  localparam int N_BTN_BOARD          = 4;

  // Counter width for a given window; kept at least one bit wide.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, registered
// level and one-cycle press/release pulses.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES
) (
  input  logic sysclk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int             CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronise the pin, count consecutive disagreeing cycles, and accept the
  // new level (with a single pulse) once the window has been fully observed.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
        press <= s2;
        rel   <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// N independent button channels: raw pins in, clean levels and edge pulses out.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN           = N_BTN_BOARD,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_125MHZ
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One self-contained channel per button; no interaction between them.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .sysclk(sysclk),
      .rst   (rst),
      .din   (btn_in[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus randomised bouncing inputs,
// checked each cycle against a window-based reference model.
module tb_btn_debounce;

  localparam int N = 4;
  localparam int D = 4;

  logic         sysclk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int vectors = 0;
  int errs    = 0;

  // Reference model state.
  logic [N-1:0] pipe_q[$];     // pin samples still travelling through the synchroniser
  logic [N-1:0] obs_hist[$];   // synchronised value seen at every edge since start
  int           start_idx[N];  // history index after the last reset/acceptance per channel
  logic [N-1:0] m_level;
  logic [N-1:0] m_press;
  logic [N-1:0] m_rel;

  int press_cnt[N];

  // Clock and reset block.
  always #4 sysclk = ~sysclk;

  btn_debounce #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // A channel accepts a new level once the last D synchronised samples since
  // its last reset/acceptance all differ from the current level.
  task automatic model_edge();
    logic [N-1:0] obs;
    int           n;
    bit           all_diff;
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      pipe_q.delete();
      pipe_q.push_back('0);
      pipe_q.push_back('0);
      m_level = '0;
      for (int i = 0; i < N; i++) start_idx[i] = obs_hist.size();
    end else begin
      obs = pipe_q.pop_front();
      pipe_q.push_back(btn_in);
      obs_hist.push_back(obs);
      n = obs_hist.size();
      for (int i = 0; i < N; i++) begin
        if (n - start_idx[i] >= D) begin
          all_diff = 1'b1;
          for (int k = 1; k <= D; k++)
            if (obs_hist[n-k][i] == m_level[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[i]   = ~m_level[i];
            m_press[i]   = m_level[i];
            m_rel[i]     = ~m_level[i];
            start_idx[i] = n;
          end
        end
      end
    end
  endtask

  // One clock: model the edge, then compare all outputs 1 ns after it.
  task automatic step();
    @(posedge sysclk);
    model_edge();
    #1;
    chk("level", 32'(btn_level), 32'(m_level));
    chk("press", 32'(btn_press), 32'(m_press));
    chk("release", 32'(btn_release), 32'(m_rel));
    chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
    for (int i = 0; i < N; i++) if (btn_press[i]) press_cnt[i]++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_press_cnt();
    for (int i = 0; i < N; i++) press_cnt[i] = 0;
  endtask

  int hold[N];

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    pipe_q.push_back('0);
    pipe_q.push_back('0);
    m_level = '0;
    for (int i = 0; i < N; i++) start_idx[i] = 0;
    clear_press_cnt();

    // Reset for three edges.
    steps(3);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_pulses", 32'(btn_press | btn_release), 32'd0);

    // 1. Clean press on channel 0: level and pulse after edge 5.
    rst    = 1'b0;
    btn_in = 4'b0001;
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e < 5) chk("t1_level_early", 32'(btn_level), 32'd0);
      if (e == 5) begin
        chk("t1_level", 32'(btn_level), 32'h1);
        chk("t1_press", 32'(btn_press), 32'h1);
      end
      if (e == 6) chk("t1_press_gone", 32'(btn_press), 32'd0);
    end

    // 2. Bounce rejection on channel 1.
    clear_press_cnt();
    for (int r = 0; r < 4; r++) begin
      btn_in[1] = (r % 2 == 0);
      steps(3);
    end
    chk("t2_no_press_bounce", 32'(press_cnt[1]), 32'd0);
    btn_in[1] = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 4) chk("t2_level_early", 32'(btn_level[1]), 32'd0);
      if (e == 5) chk("t2_level", 32'(btn_level[1]), 32'd1);
    end
    chk("t2_one_press", 32'(press_cnt[1]), 32'd1);

    // 3. Release channel 0 while channel 1 stays held.
    btn_in = 4'b0010;
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e == 5) begin
        chk("t3_level", 32'(btn_level), 32'h2);
        chk("t3_release", 32'(btn_release), 32'h1);
        chk("t3_press", 32'(btn_press), 32'd0);
      end
    end

    // 4. Simultaneous press on channels 1 and 3 from all-released.
    btn_in = '0;
    steps(8);
    chk("t4_idle", 32'(btn_level), 32'd0);
    btn_in = 4'b1010;
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e == 5) begin
        chk("t4_level", 32'(btn_level), 32'hA);
        chk("t4_press", 32'(btn_press), 32'hA);
      end
    end

    // 5. Reset mid-count on channel 2.
    btn_in = '0;
    steps(8);
    btn_in = 4'b0100;
    steps(3);
    rst = 1'b1;
    step();
    chk("t5_rst_level", 32'(btn_level), 32'd0);
    chk("t5_rst_pulse", 32'(btn_press | btn_release), 32'd0);
    rst = 1'b0;
    clear_press_cnt();
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 4) chk("t5_level_early", 32'(btn_level), 32'd0);
      if (e == 5) chk("t5_level", 32'(btn_level), 32'h4);
    end
    chk("t5_one_press", 32'(press_cnt[2]), 32'd1);

    // 6. All buttons held through reset.
    btn_in = 4'b1111;
    rst    = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      chk("t6_rst_level", 32'(btn_level), 32'd0);
      chk("t6_rst_press", 32'(btn_press), 32'd0);
    end
    rst = 1'b0;
    clear_press_cnt();
    for (int e = 0; e <= 9; e++) begin
      step();
      if (e == 4) chk("t6_level_early", 32'(btn_level), 32'd0);
      if (e == 5) chk("t6_level", 32'(btn_level), 32'hF);
    end
    for (int i = 0; i < N; i++) chk("t6_one_press", 32'(press_cnt[i]), 32'd1);

    // Random bouncing inputs with occasional resets.
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 7);
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn_in[i] = ~btn_in[i];
          hold[i]   = $urandom_range(1, 9);
        end else begin
          hold[i]--;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
